cp0_unit: RTL

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_if.sv | 35 +++
 rtl/cp0_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_if.sv
// cp0_if: bundles the CP0 coprocessor signals exchanged with the pipeline.
//   master : pipeline side; drives M-stage PC/flags, interrupts, mtc0/eret
//            strobes and the read index, and receives the read data, the EPC
//            and the exception request.
//   slave  : CP0 side (cp0_unit).
interface cp0_if;
  logic [31:0] pcM;      // M-stage PC, 0xFFFFFFFF marks a bubble
  logic        BDM;      // M-stage instruction is in a delay slot
  logic        ADELpcM;  // instruction fetch address error
  logic        RIM;      // reserved instruction
  logic        OVM;      // arithmetic overflow
  logic        ADELEXM;  // load address error
  logic        ADESEXM;  // store address error
  logic [5:0]  HWInt;    // level-sensitive external interrupts
  logic        WE;       // mtc0 write strobe
  logic [4:0]  A1;       // read register number
  logic [4:0]  A2;       // write register number
  logic [31:0] DIn;      // mtc0 write data
  logic        eretM;    // eret in M stage
  logic [31:0] DOut;     // read data of register A1
  logic [31:0] EPCout;   // current EPC
  logic        strange;  // take-exception request

  modport master (
    output pcM, BDM, ADELpcM, RIM, OVM, ADELEXM, ADESEXM, HWInt,
    output WE, A1, A2, DIn, eretM,
    input  DOut, EPCout, strange
  );

  modport slave (
    input  pcM, BDM, ADELpcM, RIM, OVM, ADELEXM, ADESEXM, HWInt,
    input  WE, A1, A2, DIn, eretM,
    output DOut, EPCout, strange
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS-style coprocessor 0 holding SR(12), Cause(13), EPC(14) and
// PrID(15). It raises the exception/interrupt request, records the victim PC,
// handles mtc0 writes and eret.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-low reset
//   bus   : cp0_if.slave (pipeline inputs, DOut/EPCout/strange outputs)
// DOut, EPCout and strange are combinational because the pipeline needs them
// in the same cycle to flush and redirect.
module cp0_unit (
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus
);

  localparam logic [31:0] BUBBLE_PC = 32'hFFFF_FFFF;
  localparam logic [31:0] PRID_VAL  = 32'h2020_1234;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Priority encoder for ExcCode; an interrupt overrides every exception flag.
  function automatic logic [4:0] sel_exccode(
    input logic int_req,
    input logic adelpc,
    input logic ri,
    input logic ov,
    input logic adelex,
    input logic adesex
  );
    logic [4:0] code;
    if (int_req) begin
      code = EXC_INT;
    end else if (adelpc) begin
      code = EXC_ADEL;
    end else if (ri) begin
      code = EXC_RI;
    end else if (ov) begin
      code = EXC_OV;
    end else if (adelex) begin
      code = EXC_ADEL;
    end else if (adesex) begin
      code = EXC_ADES;
    end else begin
      code = EXC_INT;
    end
    return code;
  endfunction

  // Architectural state
  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic        bd_r;
  logic [5:0]  ip_r;
  logic [4:0]  exccode_r;
  logic [31:0] epc_r;
  logic [31:0] lastpc_r;
  logic        lastbd_r;

  // Combinational helpers
  logic        pc_valid_s;
  logic        any_flag_s;
  logic        int_req_s;
  logic        exc_req_s;
  logic        strange_s;
  logic [31:0] victim_pc_s;
  logic        victim_bd_s;
  logic [31:0] victim_epc_s;
  logic [4:0]  exccode_s;
  logic [31:0] sr_s;
  logic [31:0] cause_s;
  logic [31:0] dout_s;

  // Request generation, victim selection and register read mux.
  always_comb begin
    pc_valid_s = (bus.pcM != BUBBLE_PC);
    any_flag_s = bus.ADELpcM | bus.RIM | bus.OVM | bus.ADELEXM | bus.ADESEXM;
    int_req_s  = (|(bus.HWInt & im_r)) & ie_r & ~exl_r;
    exc_req_s  = any_flag_s & ~exl_r;
    // Nothing is taken while reset is held, so the flush never fires on a
    // reset edge.
    if (!reset) begin
      strange_s = 1'b0;
    end else begin
      strange_s = int_req_s | exc_req_s;
    end

    // A bubble in M has no PC of its own; blame the last real instruction.
    if (pc_valid_s) begin
      victim_pc_s = bus.pcM;
      victim_bd_s = bus.BDM;
    end else begin
      victim_pc_s = lastpc_r;
      victim_bd_s = lastbd_r;
    end

    // Delay-slot victims restart at the branch, one word earlier.
    if (victim_bd_s) begin
      victim_epc_s = victim_pc_s - 32'd4;
    end else begin
      victim_epc_s = victim_pc_s;
    end

    exccode_s = sel_exccode(int_req_s, bus.ADELpcM, bus.RIM, bus.OVM,
                            bus.ADELEXM, bus.ADESEXM);

    sr_s    = {16'h0000, im_r, 8'h00, exl_r, ie_r};
    cause_s = {bd_r, 15'h0000, ip_r, 3'b000, exccode_r, 2'b00};

    case (bus.A1)
      REG_SR:    dout_s = sr_s;
      REG_CAUSE: dout_s = cause_s;
      REG_EPC:   dout_s = epc_r;
      REG_PRID:  dout_s = PRID_VAL;
      default:   dout_s = 32'h0000_0000;
    endcase
  end

  assign bus.DOut    = dout_s;
  assign bus.EPCout  = epc_r;
  assign bus.strange = strange_s;

  // CP0 register update: reset, exception entry, mtc0 and eret.
  always_ff @(posedge clk) begin
    if (!reset) begin
      im_r      <= 6'd0;
      exl_r     <= 1'b0;
      ie_r      <= 1'b0;
      bd_r      <= 1'b0;
      ip_r      <= 6'd0;
      exccode_r <= 5'd0;
      epc_r     <= 32'h0000_0000;
      lastpc_r  <= RESET_PC;
      lastbd_r  <= 1'b0;
    end else begin
      ip_r <= bus.HWInt;

      if (pc_valid_s) begin
        lastpc_r <= bus.pcM;
        lastbd_r <= bus.BDM;
      end

      if (strange_s) begin
        // Exception entry wins; any mtc0 or eret in the same cycle is dropped.
        exl_r     <= 1'b1;
        exccode_r <= exccode_s;
        bd_r      <= victim_bd_s;
        epc_r     <= victim_epc_s;
      end else begin
        if (bus.WE) begin
          case (bus.A2)
            REG_SR: begin
              im_r  <= bus.DIn[15:10];
              exl_r <= bus.DIn[1];
              ie_r  <= bus.DIn[0];
            end
            REG_EPC: begin
              epc_r <= bus.DIn;
            end
            default: begin
            end
          endcase
        end
        // Placed after the SR write so eret always leaves EXL cleared.
        if (bus.eretM) begin
          exl_r <= 1'b0;
        end
      end
    end
  end

endmodule
